// File: rtl/pattern_sequencer.sv
// Test-pattern sequencer: steps a pattern generator's mode on frame boundaries, either
// from a manual selection or by auto-cycling. Optional frame counter: PATTERN_SEQ_FRAME_CNT_EN.
module pattern_sequencer (
   input  logic        clk,
   input  logic        reset,
   input  logic        vsync_n,
   input  logic        run,
   input  logic [3:0]  manual_mode,
   input  logic [7:0]  dwell_frames,
   input  logic [3:0]  last_mode,
   output logic [3:0]  mode,
   output logic        frame_strobe,
   output logic [1:0]  seq_state,
   output logic [15:0] frame_cnt
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ARM   = 2'd1;
   localparam logic [1:0] DWELL = 2'd2;

   logic       vsync_seen;
   logic       frame_edge;
   logic [1:0] state;
   logic [7:0] dwell_cnt;
   logic [7:0] dwell_shadow;
   logic [3:0] last_shadow;
   logic [7:0] dwell_last;
   logic [3:0] last_clamped;
   logic [3:0] next_mode;

   // vsync_seen holds the previous sample as an active-high level; resetting it to 1
   // means a vsync_n already low when reset releases does not count as a frame start.
   assign frame_edge   = !vsync_n && !vsync_seen;
   assign last_clamped = (last_mode > 4'd7) ? 4'd7 : last_mode;
   assign dwell_last   = (dwell_shadow == 8'd0) ? 8'd0 : dwell_shadow - 8'd1;
   assign next_mode    = (mode >= last_shadow) ? 4'd0 : mode + 4'd1;
   assign seq_state    = state;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vsync_seen   <= 1'b1;
         frame_strobe <= 1'b0;
      end else begin
         vsync_seen   <= !vsync_n;
         frame_strobe <= frame_edge;
      end
   end

   // Dropping run always wins over auto-cycling: a coincident frame edge loads manual_mode.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         mode         <= 4'd0;
         dwell_cnt    <= 8'd0;
         dwell_shadow <= 8'd0;
         last_shadow  <= 4'd0;
      end else begin
         case (state)
            IDLE: begin
               if (frame_edge) mode <= manual_mode;
               if (run) state <= ARM;
            end
            ARM: begin
               if (!run) begin
                  state <= IDLE;
                  if (frame_edge) mode <= manual_mode;
               end else if (frame_edge) begin
                  mode         <= 4'd0;
                  dwell_cnt    <= 8'd0;
                  dwell_shadow <= dwell_frames;
                  last_shadow  <= last_clamped;
                  state        <= DWELL;
               end
            end
            DWELL: begin
               if (!run) begin
                  state <= IDLE;
                  if (frame_edge) mode <= manual_mode;
               end else if (frame_edge) begin
                  if (dwell_cnt == dwell_last) begin
                     dwell_cnt    <= 8'd0;
                     mode         <= next_mode;
                     dwell_shadow <= dwell_frames;
                     last_shadow  <= last_clamped;
                  end else begin
                     dwell_cnt <= dwell_cnt + 8'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef PATTERN_SEQ_FRAME_CNT_EN
   logic [15:0] frame_cnt_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) frame_cnt_q <= 16'd0;
      else if (frame_edge) frame_cnt_q <= frame_cnt_q + 16'd1;
   end

   assign frame_cnt = frame_cnt_q;
`else
   assign frame_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_pattern_sequencer.sv
// Scoreboard bench for pattern_sequencer: each issued frame pushes the expected mode/state,
// and a monitor pops and compares whenever frame_strobe is presented.
module tb_pattern_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        vsync_n = 1'b1;
   logic        run = 1'b0;
   logic [3:0]  manual_mode = 4'd0;
   logic [7:0]  dwell_frames = 8'd0;
   logic [3:0]  last_mode = 4'd0;
   logic [3:0]  mode;
   logic        frame_strobe;
   logic [1:0]  seq_state;
   logic [15:0] frame_cnt;

   typedef struct {
      logic [3:0] mode;
      logic [1:0] state;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   logic prev_strobe = 1'b0;
   logic [3:0] prev_mode = 4'd0;

   pattern_sequencer dut (
      .clk          (clk),
      .reset        (reset),
      .vsync_n      (vsync_n),
      .run          (run),
      .manual_mode  (manual_mode),
      .dwell_frames (dwell_frames),
      .last_mode    (last_mode),
      .mode         (mode),
      .frame_strobe (frame_strobe),
      .seq_state    (seq_state),
      .frame_cnt    (frame_cnt)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic check_output(input string name, input logic [15:0] actual, input logic [15:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   // One frame: vsync_n high for two cycles, then low; run takes run_edge with the low sample.
   task automatic apply_stimulus(input logic [3:0] exp_mode, input logic [1:0] exp_state, input logic run_edge);
      exp_t e;
      e.mode  = exp_mode;
      e.state = exp_state;
      exp_q.push_back(e);
      vsync_n = 1'b1;
      step(2);
      vsync_n = 1'b0;
      run     = run_edge;
      step(2);
   endtask

   // Monitor: compare on each strobe, check strobe width and that mode only moves with a strobe.
   always @(negedge clk) begin
      if (!reset) begin
         prev_mode   = mode;
         prev_strobe = 1'b0;
      end else begin
         if (frame_strobe) begin
            checks++;
            if (prev_strobe) begin
               errors++;
               $display("[TB] FAIL strobe_width: got strobe high on consecutive cycles, required one cycle");
            end
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("[TB] FAIL unexpected_strobe: got strobe with mode=%0d state=%0d, required no strobe", mode, seq_state);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               if (mode !== e.mode || seq_state !== e.state) begin
                  errors++;
                  $display("[TB] FAIL frame_result: got mode=%0d state=%0d, required mode=%0d state=%0d",
                           mode, seq_state, e.mode, e.state);
               end
            end
         end else if (mode !== prev_mode) begin
            checks++;
            errors++;
            $display("[TB] FAIL mid_frame_change: got mode %0d -> %0d without strobe, required hold", prev_mode, mode);
         end
         prev_mode   = mode;
         prev_strobe = frame_strobe;
      end
   end

   initial begin
      int seq_a[9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
      int seq_b[13] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1, 2, 3, 4};

      step(3);
      check_output("reset_mode", {12'd0, mode}, 16'd0);
      check_output("reset_state", {14'd0, seq_state}, 16'd0);
      check_output("reset_strobe", {15'd0, frame_strobe}, 16'd0);
      check_output("reset_frame_cnt", frame_cnt, 16'd0);
      reset = 1'b1;
      step(2);

      // Manual selection while idle
      manual_mode = 4'd6;
      apply_stimulus(4'd6, 2'd0, 1'b0);
      manual_mode = 4'd11;
      apply_stimulus(4'd11, 2'd0, 1'b0);

      // Auto cycle, dwell 2, last 3
      dwell_frames = 8'd2;
      last_mode    = 4'd3;
      run          = 1'b1;
      step(2);
      check_output("arm_state", {14'd0, seq_state}, 16'd1);
      check_output("arm_mode_hold", {12'd0, mode}, 16'd11);
      foreach (seq_a[i]) apply_stimulus(seq_a[i][3:0], 2'd2, 1'b1);

      // run drops mid-frame: back to idle, mode held until next edge
      run = 1'b0;
      step(2);
      check_output("drop_state", {14'd0, seq_state}, 16'd0);
      check_output("drop_mode_hold", {12'd0, mode}, 16'd0);
      manual_mode = 4'd5;
      apply_stimulus(4'd5, 2'd0, 1'b0);

      // Auto cycle, dwell 0 (treated as 1), last 9 clamped to 7
      dwell_frames = 8'd0;
      last_mode    = 4'd9;
      run          = 1'b1;
      step(2);
      check_output("arm_state_2", {14'd0, seq_state}, 16'd1);
      foreach (seq_b[i]) apply_stimulus(seq_b[i][3:0], 2'd2, 1'b1);
      check_output("dwell_mode4", {12'd0, mode}, 16'd4);

      // Reset mid-DWELL with vsync_n held low through release
      reset = 1'b0;
      step(1);
      check_output("abort_mode", {12'd0, mode}, 16'd0);
      check_output("abort_state", {14'd0, seq_state}, 16'd0);
      check_output("abort_frame_cnt", frame_cnt, 16'd0);
      run = 1'b0;
      step(2);
      reset = 1'b1;
      step(4);
      check_output("release_state", {14'd0, seq_state}, 16'd0);
      check_output("release_mode", {12'd0, mode}, 16'd0);
      manual_mode = 4'd3;
      apply_stimulus(4'd3, 2'd0, 1'b0);

      // run drops on the same edge as a frame start
      dwell_frames = 8'd1;
      last_mode    = 4'd7;
      run          = 1'b1;
      step(2);
      apply_stimulus(4'd0, 2'd2, 1'b1);
      apply_stimulus(4'd1, 2'd2, 1'b1);
      manual_mode = 4'd5;
      apply_stimulus(4'd5, 2'd0, 1'b0);
      check_output("edge_drop_state", {14'd0, seq_state}, 16'd0);
      check_output("edge_drop_mode", {12'd0, mode}, 16'd5);

`ifdef PATTERN_SEQ_FRAME_CNT_EN
      force dut.frame_cnt_q = 16'hFFFE;
      step(1);
      release dut.frame_cnt_q;
      apply_stimulus(4'd5, 2'd0, 1'b0);
      check_output("frame_cnt_ffff", frame_cnt, 16'hFFFF);
      apply_stimulus(4'd5, 2'd0, 1'b0);
      check_output("frame_cnt_wrap", frame_cnt, 16'h0000);
`else
      apply_stimulus(4'd5, 2'd0, 1'b0);
      check_output("frame_cnt_tied", frame_cnt, 16'h0000);
`endif

      step(3);
      check_output("scoreboard_empty", 16'(exp_q.size()), 16'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pattern_sequencer.md
PATTERN_SEQUENCER -- requirements
Module: pattern_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named as follows.
REQ-002 clk  input  1  system/pixel clock; all logic is on the rising edge.
REQ-003 reset  input  1  asynchronous active-low reset.
REQ-004 vsync_n  input  1  vertical sync from the pattern generator, synchronous to clk, active low.
REQ-005 run  input  1  level; 1 = automatic pattern cycling, 0 = manual selection.
REQ-006 manual_mode  input  4  pattern code used while not running.
REQ-007 dwell_frames  input  8  frames shown per pattern; 0 is treated as 1.
REQ-008 last_mode  input  4  highest pattern in the auto cycle; values above 7 are clamped to 7.
REQ-009 mode  output  4  pattern select driving the generator's mode input.
REQ-010 frame_strobe  output  1  one-cycle pulse per detected frame start.
REQ-011 seq_state  output  2  current FSM state: IDLE=0, ARM=1, DWELL=2.
REQ-012 frame_cnt  output  16  free-running frame count (see Configuration).

Function
REQ-013 The frame edge SHALL be defined as vsync_n sampled 0 on a clk edge after being sampled 1 on the previous edge.
REQ-014 On the clk edge that detects a frame edge, frame_strobe SHALL be registered high for exactly one cycle.
  - Any mode change caused by that edge SHALL become visible in the same cycle.
REQ-015 mode SHALL change only on a frame edge; it SHALL never change mid-frame.
REQ-016 In IDLE, at each frame edge, mode SHALL load manual_mode unmodified (0..15).
  - If run=1, the FSM SHALL go to ARM in the cycle after run is sampled 1, without waiting for a frame edge.
REQ-017 In ARM, at the next frame edge:
  - mode SHALL load 0 and the dwell counter SHALL clear;
  - the FSM SHALL go to DWELL;
  - dwell_frames and last_mode SHALL be captured into shadow registers.
REQ-018 In DWELL, each frame edge SHALL increment the 8-bit dwell counter.
  - When the counter equals eff_dwell-1 at a frame edge, the counter SHALL clear and mode SHALL advance.
  - mode advances to mode+1, or to 0 when mode equals the shadow last_mode.
  - The shadows SHALL be recaptured at every advance.
REQ-019 eff_dwell SHALL be max(dwell_frames,1); with dwell_frames=0 or 1, mode SHALL advance on every frame edge.
REQ-020 If run is sampled 0 in ARM or DWELL, the FSM SHALL go to IDLE on that edge, and mode SHALL hold until the next frame edge.
REQ-021 If run falls on the same edge as a frame edge, IDLE behaviour SHALL take priority: mode loads manual_mode on that edge.
REQ-022 If last_mode is clamped to 0, mode SHALL stay at 0 in DWELL.

Reset
REQ-023 While reset is low, the block SHALL set:
  - mode=0, frame_strobe=0, seq_state=IDLE, frame_cnt=0;
  - dwell counter=0 and both shadows=0;
  - the vsync_n history register to 1, so a low vsync_n at reset release is not an edge.
REQ-024 Reset asserted mid-operation SHALL abort the sequence immediately.
  - After release, the block SHALL wait in IDLE for run.

Configuration
REQ-025 Macro PATTERN_SEQ_FRAME_CNT_EN SHALL control the frame counter.
  - Defined: frame_cnt SHALL increment by 1 at every frame edge in any state, wrapping 0xFFFF->0x0000.
  - Undefined: frame_cnt SHALL be tied to 0 and no counter logic is built.

Verification
REQ-026 run=0, manual_mode=6, vsync_n toggles -> mode=6 exactly in the cycle after the first frame edge, frame_strobe one cycle wide, seq_state=0.
REQ-027 run=1, dwell_frames=2, last_mode=3 -> mode 0,0,1,1,2,2,3,3,0 on successive frame edges.
REQ-028 run=1, dwell_frames=0, last_mode=9 -> mode advances every frame edge through 0..7, then wraps to 0.
REQ-029 run drops on the same cycle as a frame edge with manual_mode=5 -> seq_state=0 and mode=5 on that edge; with run dropping mid-frame, mode holds until the next edge.
REQ-030 reset pulsed low while in DWELL at mode=4 -> mode=0, seq_state=0, frame_cnt=0; vsync_n held low at release produces no frame_strobe.
REQ-031 With PATTERN_SEQ_FRAME_CNT_EN defined, preload 0xFFFE, then two frame edges -> frame_cnt 0xFFFF then 0x0000; undefined -> frame_cnt stays 0.
